// File: rtl/rx_fifo_uart_if.sv
// rtl/rx_fifo_uart_if.sv - bus-side signal bundle for the rx_fifo_uart receiver
// Purpose: groups the oversample tick, serial input, FIFO pop and error
//   clear (inputs to the receiver) with the FIFO head, status and sticky
//   flags (outputs of the receiver).
// Modports:
//   master - bus / baud side: drives rx_enable, rxd, read, clr_err
//   slave  - receiver side: drives rx_out, rda, rx_count, frame_err,
//            parity_err, overrun
interface rx_fifo_uart_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 rx_enable;
  logic                 rxd;
  logic                 read;
  logic                 clr_err;
  logic [DATA_BITS-1:0] rx_out;
  logic                 rda;
  logic [CW-1:0]        rx_count;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output rx_enable, rxd, read, clr_err,
    input  rx_out, rda, rx_count, frame_err, parity_err, overrun
  );

  modport slave (
    input  rx_enable, rxd, read, clr_err,
    output rx_out, rda, rx_count, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/rx_fifo_uart.sv
// rtl/rx_fifo_uart.sv - oversampling serial receiver with FWFT receive FIFO
// Purpose: deserialises idle-high, LSB-first frames on bus.rxd using the
//   bus.rx_enable oversample tick, checks optional parity and 1 or 2 stop
//   bits, and queues good words in a first-word-fall-through FIFO with
//   sticky framing / parity / overrun flags.
// Ports:
//   clk, rst_n     - system clock, asynchronous active-low reset
//   bus (slave)    - rx_enable, rxd, read, clr_err in;
//                    rx_out, rda, rx_count, frame_err, parity_err, overrun out
module rx_fifo_uart #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  rx_fifo_uart_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int IW = 4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // input synchroniser, idle level is high
  logic r_sync1;
  logic r_rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= bus.rxd;
      r_rxs   <= r_sync1;
    end
  end

  state_t               r_state, w_state_n;
  logic [TW-1:0]        r_cnt, w_cnt_n;
  logic [IW-1:0]        r_idx, w_idx_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_par_bad, w_par_bad_n;
  logic                 r_stop_bad, w_stop_bad_n;
  logic                 w_done;
  logic                 w_bit_tick;
  logic                 w_par_exp;

  assign w_bit_tick = (r_cnt == TW'(OVERSAMPLE - 1));
  assign w_par_exp  = (^r_shift) ^ 1'(PARITY_ODD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par_bad  <= 1'b0;
      r_stop_bad <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_idx      <= w_idx_n;
      r_shift    <= w_shift_n;
      r_par_bad  <= w_par_bad_n;
      r_stop_bad <= w_stop_bad_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_idx_n      = r_idx;
    w_shift_n    = r_shift;
    w_par_bad_n  = r_par_bad;
    w_stop_bad_n = r_stop_bad;
    w_done       = 1'b0;
    if (bus.rx_enable) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            w_state_n    = S_START;
            w_cnt_n      = TW'(1);
            w_idx_n      = '0;
            w_par_bad_n  = 1'b0;
            w_stop_bad_n = 1'b0;
          end
        end
        S_START: begin
          // the tick that would bring cnt to OVERSAMPLE/2 is mid start bit
          if (r_cnt == TW'(OVERSAMPLE / 2 - 1)) begin
            w_cnt_n   = '0;
            w_idx_n   = '0;
            w_state_n = r_rxs ? S_IDLE : S_DATA;
          end else begin
            w_cnt_n = r_cnt + TW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_tick) begin
            w_cnt_n = '0;
            // right shift in at the MSB: after DATA_BITS samples bit 0 is first
            w_shift_n = {r_rxs, r_shift[DATA_BITS-1:1]};
            if (r_idx == IW'(DATA_BITS - 1)) begin
              w_idx_n   = '0;
              w_state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              w_idx_n = r_idx + IW'(1);
            end
          end else begin
            w_cnt_n = r_cnt + TW'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_tick) begin
            w_cnt_n     = '0;
            w_par_bad_n = (r_rxs != w_par_exp);
            w_state_n   = S_STOP;
          end else begin
            w_cnt_n = r_cnt + TW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_tick) begin
            w_cnt_n      = '0;
            w_stop_bad_n = r_stop_bad | ~r_rxs;
            if (r_idx == IW'(STOP_BITS - 1)) begin
              w_idx_n   = '0;
              w_done    = 1'b1;
              w_state_n = S_IDLE;
            end else begin
              w_idx_n = r_idx + IW'(1);
            end
          end else begin
            w_cnt_n = r_cnt + TW'(1);
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // frame verdict, framing > parity > overrun
  logic w_stop_fail;
  logic w_push_try;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_full;
  logic w_set_frame;
  logic w_set_parity;
  logic w_set_overrun;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wptr;
  logic [AW:0]          r_rptr;
  logic [AW:0]          w_used;

  assign w_stop_fail   = r_stop_bad | ~r_rxs;
  assign w_set_frame   = w_done & w_stop_fail;
  assign w_set_parity  = w_done & ~w_stop_fail & r_par_bad;
  assign w_push_try    = w_done & ~w_stop_fail & ~r_par_bad;
  assign w_empty       = (r_wptr == r_rptr);
  assign w_full        = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop         = bus.read & ~w_empty;
  // a same-cycle pop frees the slot a full FIFO would otherwise refuse
  assign w_push        = w_push_try & (~w_full | w_pop);
  assign w_set_overrun = w_push_try & w_full & ~w_pop;
  assign w_used        = r_wptr - r_rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= w_shift_n;
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  logic r_frame_err;
  logic r_parity_err;
  logic r_overrun;

  // a flag being set beats a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_set_frame)      r_frame_err <= 1'b1;
      else if (bus.clr_err) r_frame_err <= 1'b0;
      if (w_set_parity)     r_parity_err <= 1'b1;
      else if (bus.clr_err) r_parity_err <= 1'b0;
      if (w_set_overrun)    r_overrun <= 1'b1;
      else if (bus.clr_err) r_overrun <= 1'b0;
    end
  end

  assign bus.rx_out     = r_mem[r_rptr[AW-1:0]];
  assign bus.rda        = ~w_empty;
  assign bus.rx_count   = CW'(w_used);
  assign bus.frame_err  = r_frame_err;
  assign bus.parity_err = r_parity_err;
  assign bus.overrun    = r_overrun;
endmodule

// File: doc/rx_fifo_uart.md
# rx_fifo_uart

Parametrised successor to the SPART receiver. It deserialises asynchronous serial frames on `rxd` using the oversampling tick `rx_enable`. Data width, oversample ratio, parity mode and stop-bit count are configurable, and parity is optional. Received words go into an internal first-word-fall-through FIFO with sticky framing/parity/overrun flags. The block sits between the SPART baud generator and the bus interface, in place of the single-buffer receiver.

## Interface
- `DATA_BITS`, 8: payload bits per frame, legal 5..9
- `OVERSAMPLE`, 16: `rx_enable` ticks per bit period, even, ≥4
- `FIFO_DEPTH`, 4: receive FIFO entries, power of two, ≥2
- `PARITY_EN`, 0: 1 = parity bit follows data
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even (ignored if `PARITY_EN`=0)
- `STOP_BITS`, 1: 1 or 2 stop bits checked
- `clk` in 1: system clock; all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `rx_enable` in 1: one-`clk` pulse per 1/`OVERSAMPLE` bit period
- `rxd` in 1: serial input, idle high, LSB first
- `read` in 1: pop FIFO head (ignored when empty)
- `clr_err` in 1: clears all sticky error flags
- `rx_out` out `DATA_BITS`: FIFO head word, valid while `rda`=1
- `rda` out 1: FIFO non-empty
- `rx_count` out clog2(`FIFO_DEPTH`+1): FIFO occupancy
- `frame_err` out 1: sticky, stop bit sampled low
- `parity_err` out 1: sticky, parity mismatch
- `overrun` out 1: sticky, good frame dropped because FIFO full

## Operation
- `rxd` passes through a 2-flop synchroniser clocked every `clk` (not gated by `rx_enable`). The synchroniser resets to 1. All sampling uses the synchronised value `rxs`.
- States: IDLE, START, DATA, PARITY, STOP. Tick counter `cnt`, bit index `idx`.
- IDLE: on a tick with `rxs`=0, go to START with `cnt`=1.
- START: on each tick, increment `cnt`. At `cnt`=`OVERSAMPLE`/2 (mid start bit):
  - if `rxs`=0, go to DATA with `cnt`=0, `idx`=0;
  - otherwise the start was a glitch: go back to IDLE and set no flags.
- Later samples occur on the `OVERSAMPLE`-th tick after the previous sample (`cnt` counts 0..`OVERSAMPLE`-1).
- DATA: shift `rxs` into bit `idx`, filling LSB first. After bit `DATA_BITS`-1, go to PARITY if `PARITY_EN`, else STOP.
- PARITY: compare `rxs` against the XOR of the data bits, inverted when `PARITY_ODD`. Record a mismatch and go to STOP.
- STOP: sample `STOP_BITS` stop bits. After the last sample, return to IDLE.
  - Any stop sample of 0: set `frame_err`, discard the word.
  - Otherwise, a recorded parity mismatch: set `parity_err`, discard the word.
  - Otherwise, FIFO full and no pop this cycle: set `overrun`, discard the word.
  - Otherwise: push the word.
- Frame-check precedence is framing > parity > overrun. Exactly one flag is set per bad frame.
- FIFO:
  - read and write pointers of clog2(`FIFO_DEPTH`)+1 bits, wrapping modulo 2·`FIFO_DEPTH`;
  - full and empty are distinguished by the pointer MSBs;
  - `rx_out` is combinationally the head entry.
- Push and pop in the same cycle:
  - FIFO full: the pop frees a slot and the push succeeds; no overrun, count unchanged.
  - FIFO empty: the pop is ignored and the push succeeds.
- `read` when empty: no effect. `rx_count` never underflows or exceeds `FIFO_DEPTH`.
- `clr_err`:
  - clears all three flags;
  - if a flag-setting event lands in the same cycle, the set wins;
  - does not affect the FIFO or the FSM.
- `rx_enable` low: the FSM and counters hold. FIFO pops and `clr_err` still act.

## Timing
- Reset values:
  - `rda`=0, `rx_count`=0, `rx_out`=0 (entries cleared);
  - all error flags 0;
  - FSM in IDLE, `cnt`=`idx`=0, synchroniser flops=1.
- A reset mid-frame abandons the frame. Reception restarts cleanly with the next falling edge after `rst_n` deasserts.
- Input latency: 2 `clk` from `rxd` to `rxs`.
- Push: on the `clk` edge of the final stop-sample tick. `rda`, `rx_count` and `rx_out` update at that edge, so they are visible in the following cycle.
- Flags set at the same edge as the would-be push.
- Pop: `rx_out` shows the next entry and `rda`/`rx_count` update the cycle after `read` is sampled high.
- Start detect to final stop sample: `OVERSAMPLE`/2 − 1 + (`DATA_BITS` + `PARITY_EN` + `STOP_BITS`)·`OVERSAMPLE` ticks.
- Back-to-back frames:
  - the FSM is in IDLE one tick after the last stop sample and accepts a new start bit on the next tick;
  - falling-edge-to-falling-edge spacing of (frame length in bits)·`OVERSAMPLE` ticks must be received without loss.

## Test plan
1. Defaults; frame 0x88 (bits 0,0,0,1,0,0,0,1), stop=1 -> after stop sample `rda`=1, `rx_out`=0x88, `rx_count`=1, no flags. `read` pulse -> next cycle `rda`=0, `rx_count`=0.
2. `rxd` low for 4 ticks then high -> FSM returns to IDLE, `rx_count`=0, all flags 0. A following valid frame 0x5A is received correctly.
3. Frame 0x3C with stop bit 0 -> `frame_err`=1, `rx_count` unchanged. `clr_err` pulse -> `frame_err`=0 next cycle.
4. Five frames 0x01..0x05, no reads:
   - `rx_count`=4, `overrun`=1, `rx_out`=0x01.
   - Repeat with `read` asserted on the 5th push cycle -> no overrun, FIFO holds 0x02..0x05.
5. `PARITY_EN`=1, even parity:
   - 0x07 with parity 0 -> `parity_err`=1, word dropped;
   - 0x07 with parity 1 -> pushed.
   - `PARITY_ODD`=1 with parity 0 -> pushed.
6. `DATA_BITS`=7, `STOP_BITS`=2: assert `rst_n`=0 mid-DATA -> all outputs at reset values. Frame 0x55 afterwards -> `rx_out`=0x55. A second stop bit of 0 -> `frame_err`=1.
